text_label_renderer: RTL

TEXT_LABEL_RENDERER -- requirements
Module: text_label_renderer

---
 rtl/text_pkg.sv | 15 +
 rtl/char_buffer.sv | 46 ++++
 rtl/text_label_renderer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// text_pkg: shared constants and FSM state type for the text label renderer.
// No ports; imported by char_buffer and text_label_renderer.
package text_pkg;

    localparam int CHAR_W      = 8;
    localparam int CHAR_H      = 16;
    localparam int FONT_ADDR_W = 11;
    localparam int ASCII_W     = 7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/char_buffer.sv
// char_buffer: NUM_CHARS x 7-bit register file, one write port, one
// combinational read port, asynchronous active-high reset to 0x00.
// Ports: Clk, Reset, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module char_buffer
    import text_pkg::*;
#(
    parameter  int NUM_CHARS = 8,
    localparam int IW        = $clog2(NUM_CHARS)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               we_i,
    input  logic [IW-1:0]      waddr_i,
    input  logic [ASCII_W-1:0] wdata_i,
    input  logic [IW-1:0]      raddr_i,
    output logic [ASCII_W-1:0] rdata_o
);

    logic [ASCII_W-1:0] mem_q [NUM_CHARS];

    // Decoded loops keep non-power-of-two sizes safe: addresses past the
    // last cell simply match nothing.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                if (waddr_i == IW'(i)) begin
                    mem_q[i] <= wdata_i;
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (raddr_i == IW'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/text_label_renderer.sv
// text_label_renderer: renders a NUM_CHARS-cell ASCII label through an
// external synchronous 8x16 font ROM with a fixed 3-edge scan latency.
// Ports: Clk, Reset, DrawX/DrawY (scan position), wr_en/wr_idx/wr_char/clr
// (buffer update, accepted when wr_ready), font_addr/font_data (ROM),
// in_box/pixel_on (delayed label box flag and foreground pixel).
module text_label_renderer
    import text_pkg::*;
#(
    parameter  int START_X   = 364,
    parameter  int START_Y   = 400,
    parameter  int NUM_CHARS = 8,
    localparam int IW        = $clog2(NUM_CHARS)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [12:0]            DrawX,
    input  logic [12:0]            DrawY,
    input  logic                   wr_en,
    input  logic [IW-1:0]          wr_idx,
    input  logic [ASCII_W-1:0]     wr_char,
    input  logic                   clr,
    output logic                   wr_ready,
    output logic [FONT_ADDR_W-1:0] font_addr,
    input  logic [7:0]             font_data,
    output logic                   in_box,
    output logic                   pixel_on
);

    localparam logic [12:0] X_LO = 13'(START_X);
    localparam logic [12:0] X_HI = 13'(START_X + CHAR_W * NUM_CHARS);
    localparam logic [12:0] Y_LO = 13'(START_Y);
    localparam logic [12:0] Y_HI = 13'(START_Y + CHAR_H);
    localparam logic [IW:0]   NC   = (IW + 1)'(NUM_CHARS);
    localparam logic [IW-1:0] LAST = IW'(NUM_CHARS - 1);

    // Buffer control
    state_e             state_q, state_d;
    logic [IW-1:0]      cnt_q, cnt_d;
    logic               we;
    logic [IW-1:0]      waddr;
    logic [ASCII_W-1:0] wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        waddr   = wr_idx;
        wdata   = wr_char;
        unique case (state_q)
            ST_IDLE: begin
                // clr has priority; a simultaneous write is dropped
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (wr_en && ({1'b0, wr_idx} < NC)) begin
                    we = 1'b1;
                end
            end
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_ready = (state_q == ST_IDLE) && !Reset;

    // Scan decode: cell/col from DrawX offset, glyph row from DrawY offset
    logic               hit;
    logic [IW+2:0]      dx;
    logic [3:0]         dy;
    logic [ASCII_W-1:0] rd_char;

    assign hit = (DrawX >= X_LO) && (DrawX < X_HI) &&
                 (DrawY >= Y_LO) && (DrawY < Y_HI);
    assign dx  = (IW + 3)'(DrawX - X_LO);
    assign dy  = 4'(DrawY - Y_LO);

    // Combinational read sees the pre-write value during a same-edge write
    char_buffer #(.NUM_CHARS(NUM_CHARS)) u_buf (
        .Clk     (Clk),
        .Reset   (Reset),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (dx[IW+2:3]),
        .rdata_o (rd_char)
    );

    // E1: ROM address plus side info; E2: align with font_data; E3: output
    logic [FONT_ADDR_W-1:0] fa_d, fa_q;
    logic [2:0]             col1_q, col2_q;
    logic                   in1_q, in2_q, blk1_q, blk2_q;
    logic                   in_box_q, pix_q, pix_d;

    assign fa_d  = hit ? {rd_char, dy} : '0;
    assign pix_d = in2_q && !blk2_q && font_data[3'd7 - col2_q];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fa_q     <= '0;
            col1_q   <= '0;
            col2_q   <= '0;
            in1_q    <= 1'b0;
            in2_q    <= 1'b0;
            blk1_q   <= 1'b0;
            blk2_q   <= 1'b0;
            in_box_q <= 1'b0;
            pix_q    <= 1'b0;
        end else begin
            fa_q     <= fa_d;
            col1_q   <= hit ? dx[2:0] : 3'd0;
            col2_q   <= col1_q;
            in1_q    <= hit;
            in2_q    <= in1_q;
            blk1_q   <= hit && (rd_char == '0);
            blk2_q   <= blk1_q;
            in_box_q <= in2_q;
            pix_q    <= pix_d;
        end
    end

    assign font_addr = fa_q;
    assign in_box    = in_box_q;
    assign pixel_on  = pix_q;

endmodule
